ff_handshake_tx: RTL

- Source-side (transmitting) end of a 4-phase req/ack clock-domain-crossing handshake.
- Lives in the clk_a domain. Takes a valid/ready word from local logic and presents it to a destination domain as a held data bus plus a level req.
- Synchronizes the returning asynchronous ack with an internal flop chain.
- Includes a watchdog timeout with a sticky error flag.

---
 rtl/ff_handshake_tx.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ff_handshake_tx.sv
// -----------------------------------------------------------------------------
// ff_handshake_tx
// Source (transmitting) side of a 4-phase req/ack clock-domain-crossing
// handshake. The block lives in the clk_a domain. It takes one word from local
// valid/ready logic, holds it on data_b and raises req_b, then waits for the
// destination's ack to rise and fall again. The ack is brought into clk_a
// through a SYNC_STAGES flop chain. A per-phase watchdog moves the FSM to an
// error state and raises a sticky flag if the destination stops responding.
//
// Ports
//   clk_a       in   source-domain clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   src_valid   in   local word available
//   src_data    in   local word [DATA_W]
//   src_ready   out  block accepts a word this cycle (state is IDLE)
//   req_b       out  registered request level to the destination domain
//   data_b      out  registered data, held stable while req_b=1 [DATA_W]
//   ack_b       in   asynchronous acknowledge from the destination domain
//   busy        out  handshake in progress (state not IDLE)
//   timeout_err out  sticky watchdog error
//   err_clr     in   clears the error; only acted on in the error state
// -----------------------------------------------------------------------------
module ff_handshake_tx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk_a,
    input  logic              rst_n,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic              req_b,
    output logic [DATA_W-1:0] data_b,
    input  logic              ack_b,
    output logic              busy,
    output logic              timeout_err,
    input  logic              err_clr
);

    // A synchronizer shorter than two flops is not safe; clamp it.
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic             WD_EN   = (TIMEOUT_CYC != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_LOW = 2'd2,
        ST_ERR      = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [SYNC_N-1:0]   sync_q, sync_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                req_q, req_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic                ack_s;
    logic                tmo_hit_s;
    logic [CNT_W-1:0]    cnt_inc_s;

    assign ack_s     = sync_q[SYNC_N-1];
    // The watchdog fires only when enabled and the phase counter has reached
    // the limit; the exit test in the FSM is checked first so it wins a tie.
    assign tmo_hit_s = WD_EN & (cnt_q == TMO_VAL);
    assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);

    assign src_ready   = (state_q == ST_IDLE);
    assign req_b       = req_q;
    assign data_b      = data_q;
    assign busy        = busy_q;
    assign timeout_err = err_q;

    // State register plus all registered outputs and the ack synchronizer.
    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sync_q  <= {SYNC_N{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            req_q   <= 1'b0;
            data_q  <= {DATA_W{1'b0}};
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Next-state and phase-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sync_d  = {sync_q[SYNC_N-2:0], ack_b};
        case (state_q)
            ST_IDLE: begin
                // A high ack here is spurious and deliberately ignored.
                if (src_valid) begin
                    state_d = ST_REQ;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    state_d = ST_WAIT_LOW;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (tmo_hit_s) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d   = cnt_inc_s;
                end
            end
            ST_WAIT_LOW: begin
                if (!ack_s) begin
                    state_d = ST_IDLE;
                end else if (tmo_hit_s) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d   = cnt_inc_s;
                end
            end
            ST_ERR: begin
                // Recovery goes through WAIT_LOW so the destination's ack
                // must be seen low before another word is accepted.
                if (err_clr) begin
                    state_d = ST_WAIT_LOW;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_ERR;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Registered-output values derived from the next state.
    always_comb begin
        req_d  = (state_d == ST_REQ);
        busy_d = (state_d != ST_IDLE);
        err_d  = (state_d == ST_ERR);
        // The data bus only loads on an accepted word and is otherwise frozen.
        if ((state_q == ST_IDLE) && src_valid) begin
            data_d = src_data;
        end else begin
            data_d = data_q;
        end
    end

endmodule
